// File: rtl/mul_tree_out_collector.sv
// mul_tree_out_collector
//   Collects per-lane results from mul_tree_bf16. Each lane has its own small
//   FIFO because lanes strobe independently. When every active lane has data,
//   one lane-aligned word is presented downstream.
//
//   Handshake: a word transfers on any rising edge where out_valid && out_ready.
//   While out_valid is high and out_ready is low, out_data/out_mask stay stable.
//   out_valid never drops without a transfer, except on rst.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   mode       tree mode (00: 4 lanes, 01: lanes 0/2, 10: lane 0, 11: as 00)
//   in_data    tree outputs, lane k at [k*DW +: DW]
//   in_stb     per-lane strobe qualifying in_data
//   out_data   aligned result word, inactive lanes zero
//   out_mask   active-lane mask of the word in out_data
//   out_valid  out_data/out_mask hold a word
//   out_ready  downstream accepts the word
//   ovf        sticky per-lane overflow (sample dropped on full lane)
//   out_count  handshake counter, present only with MUL_COLLECT_CNT_EN
//
// Optional feature macro: MUL_COLLECT_CNT_EN
module mul_tree_out_collector #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      mode,
  input  logic [4*DW-1:0] in_data,
  input  logic [3:0]      in_stb,
  output logic [4*DW-1:0] out_data,
  output logic [3:0]      out_mask,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      ovf
`ifdef MUL_COLLECT_CNT_EN
  ,
  output logic [15:0]     out_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem    [4][DEPTH];
  logic [AW-1:0] wr_ptr [4];
  logic [AW-1:0] rd_ptr [4];
  logic [CW-1:0] cnt    [4];

  logic [1:0]      mode_q;
  logic [3:0]      mask;
  logic [3:0]      lane_empty;
  logic [3:0]      lane_full;
  logic [3:0]      push;
  logic [3:0]      drop;
  logic [3:0]      pop_lane;
  logic            pop;
  logic            idle;
  logic [4*DW-1:0] head_word;

  always_comb begin
    mask = 4'b1111;
    case (mode_q)
      2'b01:   mask = 4'b0101;
      2'b10:   mask = 4'b0001;
      default: mask = 4'b1111;
    endcase
  end

  always_comb begin
    lane_empty = '0;
    lane_full  = '0;
    head_word  = '0;
    for (int k = 0; k < 4; k++) begin
      lane_empty[k] = (cnt[k] == '0);
      lane_full[k]  = (cnt[k] == CW'(DEPTH));
      if (mask[k]) head_word[k*DW +: DW] = mem[k][rd_ptr[k]];
    end
  end

  // Inactive lanes never block a pop; the register is free if empty or draining.
  assign pop      = (&(~lane_empty | ~mask)) && (!out_valid || out_ready);
  assign pop_lane = pop ? mask : 4'b0000;
  // A full lane still accepts a push when it pops in the same cycle.
  assign push     = in_stb & mask & (~lane_full | pop_lane);
  assign drop     = in_stb & mask & lane_full & ~pop_lane;
  assign idle     = (&lane_empty) && !out_valid;

  // Storage has no reset; only pointers and counts define contents.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (push[k]) mem[k][wr_ptr[k]] <= in_data[k*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        cnt[k]    <= '0;
      end
      ovf    <= '0;
      mode_q <= 2'b10;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (push[k])     wr_ptr[k] <= wr_ptr[k] + AW'(1);
        if (pop_lane[k]) rd_ptr[k] <= rd_ptr[k] + AW'(1);
        if (push[k] && !pop_lane[k])      cnt[k] <= cnt[k] + CW'(1);
        else if (!push[k] && pop_lane[k]) cnt[k] <= cnt[k] - CW'(1);
      end
      ovf <= ovf | drop;
      // Mode only moves between words so no word mixes two lane layouts.
      if (idle) mode_q <= mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mask  <= 4'b0001;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_data  <= head_word;
      out_mask  <= mask;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUL_COLLECT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) out_count <= '0;
    else if (out_valid && out_ready) out_count <= out_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mul_tree_out_collector.sv
module tb_mul_tree_out_collector;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]      mode      = 2'b10;
  logic [4*DW-1:0] in_data   = '0;
  logic [3:0]      in_stb    = '0;
  logic            out_ready = 1'b0;
  logic [4*DW-1:0] out_data;
  logic [3:0]      out_mask;
  logic            out_valid;
  logic [3:0]      ovf;
`ifdef MUL_COLLECT_CNT_EN
  logic [15:0]     out_count;
`endif

  mul_tree_out_collector #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_data   (in_data),
    .in_stb    (in_stb),
    .out_data  (out_data),
    .out_mask  (out_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf)
`ifdef MUL_COLLECT_CNT_EN
    ,
    .out_count (out_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0]   lq [4][DEPTH];   // lane contents, index 0 is the oldest
  int              lc [4];
  logic            m_valid = 1'b0;
  logic [4*DW-1:0] m_data  = '0;
  logic [3:0]      m_mask  = 4'b0001;
  logic [3:0]      m_ovf   = '0;
  logic [1:0]      m_mode  = 2'b10;
  logic [15:0]     m_cnt   = '0;
  logic            started = 1'b0;
  logic [63:0]     exp_q[$];        // words the DUT must deliver, in order

  function automatic logic [3:0] mask_of(input logic [1:0] m);
    case (m)
      2'b01:   return 4'b0101;
      2'b10:   return 4'b0001;
      default: return 4'b1111;
    endcase
  endfunction

  initial begin
    for (int k = 0; k < 4; k++) lc[k] = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int k = 0; k < 4; k++) lc[k] = 0;
        m_valid = 1'b0; m_data = '0; m_mask = 4'b0001; m_ovf = '0;
        m_mode = 2'b10; m_cnt = '0; exp_q.delete(); started = 1'b1;
      end else if (started) begin
        logic [3:0]      mk;
        logic            idle, hs, have_all, pop;
        logic [4*DW-1:0] w;
        mk = mask_of(m_mode);
        idle = !m_valid;
        for (int k = 0; k < 4; k++) if (lc[k] != 0) idle = 1'b0;
        hs = m_valid && out_ready;
        have_all = 1'b1;
        for (int k = 0; k < 4; k++) if (mk[k] && lc[k] == 0) have_all = 1'b0;
        pop = have_all && (!m_valid || out_ready);
        if (pop) begin
          w = '0;
          for (int k = 0; k < 4; k++) begin
            if (mk[k]) begin
              w[k*DW +: DW] = lq[k][0];
              for (int j = 0; j < DEPTH-1; j++) lq[k][j] = lq[k][j+1];
              lc[k]--;
            end
          end
          m_valid = 1'b1; m_data = w; m_mask = mk;
          exp_q.push_back(w);
        end else if (hs) begin
          m_valid = 1'b0;
        end
        // A pop frees room before the pushes of the same edge are judged.
        for (int k = 0; k < 4; k++) begin
          if (in_stb[k] && mk[k]) begin
            if (lc[k] < DEPTH) begin
              lq[k][lc[k]] = in_data[k*DW +: DW];
              lc[k]++;
            end else begin
              m_ovf[k] = 1'b1;
            end
          end
        end
        if (hs) m_cnt = m_cnt + 16'd1;
        if (idle) m_mode = mode;
      end
    end
  end

  // ---------------- compare process (falling edge) ----------------
  int              hs_count = 0;
  logic            prev_hold = 1'b0;
  logic [4*DW-1:0] prev_data;
  logic [3:0]      prev_mask;

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_data", out_data, m_data);
        check("out_mask", 64'(out_mask), 64'(m_mask));
        check("ovf", 64'(ovf), 64'(m_ovf));
`ifdef MUL_COLLECT_CNT_EN
        check("out_count", 64'(out_count), 64'(m_cnt));
`endif
        if (prev_hold) begin
          check("hold_data", out_data, prev_data);
          check("hold_mask", 64'(out_mask), 64'(prev_mask));
        end
        if (out_valid && out_ready) begin
          hs_count++;
          if (exp_q.size() == 0) begin
            check("scoreboard_empty", 64'(out_data), 64'hx);
          end else begin
            check("scoreboard_word", out_data, exp_q.pop_front());
          end
        end
        prev_hold = out_valid && !out_ready && !rst;
        prev_data = out_data;
        prev_mask = out_mask;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_stb = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic strobe(input logic [3:0] stb, input logic [63:0] data);
    in_stb = stb;
    in_data = data;
    tick();
    in_stb = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] w;
    int hs0;

    // Reset state and single-lane latency in mode 10.
    mode = 2'b10;
    do_reset();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", out_data, 64'd0);
    check("rst_mask", 64'(out_mask), 64'h1);
    check("rst_ovf", 64'(ovf), 64'd0);
    out_ready = 1'b1;
    strobe(4'b0001, 64'h0000_0000_0000_3F80);
    check("t1_lat1_valid", 64'(out_valid), 64'd0);
    tick();
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_data", out_data, 64'h0000_0000_0000_3F80);
    check("t1_mask", 64'(out_mask), 64'h1);
    tick();
    check("t1_drained", 64'(out_valid), 64'd0);

    // Mode 00, lanes arrive in different cycles.
    mode = 2'b00;
    tick(); tick();
    strobe(4'b1000, 64'h40C0_0000_0000_0000);
    strobe(4'b0100, 64'h0000_4080_0000_0000);
    strobe(4'b0010, 64'h0000_0000_4040_0000);
    strobe(4'b0001, 64'h0000_0000_0000_4000);
    check("t2_early_valid", 64'(out_valid), 64'd0);
    tick();
    check("t2_valid", 64'(out_valid), 64'd1);
    check("t2_data", out_data, 64'h40C0_4080_4040_4000);
    check("t2_mask", 64'(out_mask), 64'hF);
    tick();
    check("t2_single_word", 64'(out_valid), 64'd0);

    // Mode 01, lane 0 overflows while lane 2 is empty.
    mode = 2'b01;
    out_ready = 1'b0;
    tick(); tick();
    for (int i = 1; i <= 5; i++) strobe(4'b0011, 64'(16'h1000 + 16'(i)));
    tick();
    check("t3_valid", 64'(out_valid), 64'd0);
    check("t3_ovf", 64'(ovf), 64'h1);
    out_ready = 1'b1;
    strobe(4'b0100, 64'h0000_2000_0000_0000);
    tick();
    check("t3_word", out_data, 64'h0000_2000_0000_1001);
    check("t3_mask", 64'(out_mask), 64'h5);
    for (int i = 0; i < 4; i++) strobe(4'b0100, 64'(32'h2001 + i) << 32);
    for (int i = 0; i < 4; i++) tick();

    // Mode 00, all lanes with toggling out_ready; 16 words.
    mode = 2'b00;
    do_reset();
    tick();
    hs0 = hs_count;
    for (int i = 0; i < 32; i++) begin
      out_ready = (i % 2 == 0);
      in_stb = (i % 2 == 0) ? 4'hF : 4'h0;
      in_data = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      tick();
    end
    in_stb = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("t4_words", 64'(hs_count - hs0), 64'd16);
    check("t4_ovf", 64'(ovf), 64'd0);

    // Mode change deferred while lane 0 still has words.
    mode = 2'b10;
    do_reset();
    out_ready = 1'b0;
    strobe(4'b0001, 64'hA001);
    strobe(4'b0001, 64'hA002);
    strobe(4'b0001, 64'hA003);
    mode = 2'b00;
    out_ready = 1'b1;
    tick();
    check("t5_w2_data", out_data, 64'hA002);
    check("t5_w2_mask", 64'(out_mask), 64'h1);
    tick();
    check("t5_w3_data", out_data, 64'hA003);
    check("t5_w3_mask", 64'(out_mask), 64'h1);
    tick();
    check("t5_idle", 64'(out_valid), 64'd0);
    tick();
    strobe(4'hF, 64'hB004_B003_B002_B001);
    tick();
    check("t5_new_data", out_data, 64'hB004_B003_B002_B001);
    check("t5_new_mask", 64'(out_mask), 64'hF);
    tick();

    // Randomised traffic with occasional mode changes and one reset.
    for (int i = 0; i < 400; i++) begin
      if (i % 60 == 0) mode = 2'($urandom_range(0, 3));
      rst = (i == 200);
      in_stb = 4'($urandom_range(0, 15));
      in_data = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0;
    in_stb = '0;

    // Reset while a word is held and FIFOs are half full.
    mode = 2'b00;
    do_reset();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      strobe(4'hF, w);
    end
    check("t6_held", 64'(out_valid), 64'd1);
    mode = 2'b10;
    do_reset();
    check("t6_valid", 64'(out_valid), 64'd0);
    check("t6_ovf", 64'(ovf), 64'd0);
    check("t6_mask", 64'(out_mask), 64'h1);
`ifdef MUL_COLLECT_CNT_EN
    check("t6_cnt0", 64'(out_count), 64'd0);
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) strobe(4'b0001, 64'(16'hC000 + 16'(i)));
    for (int i = 0; i < 3; i++) tick();
`ifdef MUL_COLLECT_CNT_EN
    check("t6_cnt3", 64'(out_count), 64'd3);
`endif
    check("t6_valid_end", 64'(out_valid), 64'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
